// File: rtl/cdcm_tx_pkg.sv
// cdcm_tx_pkg: shared state type and waveform/offset-table helpers for the CDCM transmitter
package cdcm_tx_pkg;
  typedef enum logic [1:0] {TRAIN, SCAN, RUN} state_t;
  function automatic logic [63:0] pulse_word(input int width, input int k);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 64; j++) w[j] = (j < width) && (j >= width - k);
    return w;
  endfunction
  function automatic logic [31:0] offset_entry(input int i, input int taps, input int width);
    logic [31:0] v;
    v = 32'(i - taps / 2);
    return width >= 32 ? v : v & ((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/cdcm_pulse_encoder.sv
// cdcm_pulse_encoder: maps one payload bit to a duty-cycle word, idle when no bit is presented
module cdcm_pulse_encoder
  import cdcm_tx_pkg::*;
#(
  parameter int kDevW     = 8,
  parameter int kModDepth = 1
) (
  input  logic             i_bit,
  input  logic             i_valid,
  output logic [kDevW-1:0] o_word
);
  localparam logic [63:0] IDLE_W = pulse_word(kDevW, kDevW / 2);
  localparam logic [63:0] ONE_W  = pulse_word(kDevW, kDevW / 2 + kModDepth);
  localparam logic [63:0] ZERO_W = pulse_word(kDevW, kDevW / 2 - kModDepth);
  assign o_word = !i_valid ? IDLE_W[kDevW-1:0] : i_bit ? ONE_W[kDevW-1:0] : ZERO_W[kDevW-1:0];
endmodule

// File: rtl/cdcm_tx_scan_encoder.sv
// cdcm_tx_scan_encoder: CDCM transmit front-end sequencing training, offset scan, then payload
module cdcm_tx_scan_encoder
  import cdcm_tx_pkg::*;
#(
  parameter int kDevW         = 8,
  parameter int kModDepth     = 1,
  parameter int kNumTaps      = 8,
  parameter int kWidthScanTdc = 8,
  parameter int kTrainLen     = 64
) (
  input  logic                              clkIn,
  input  logic                              resetN,
  input  logic                              restartScan,
  input  logic                              txData,
  input  logic                              txValid,
  output logic                              txReady,
  output logic [kDevW-1:0]                  dOutToDevice,
  output logic [kNumTaps*kWidthScanTdc-1:0] offsetTable,
  output logic                              scanFinished
);
  localparam int kCntW = $clog2(kTrainLen > kNumTaps ? kTrainLen : kNumTaps) + 1;
  localparam logic [63:0] IDLE_W = pulse_word(kDevW, kDevW / 2);
  state_t r_state, w_state_nxt;
  logic [kCntW-1:0] r_cnt, w_cnt_nxt;
  logic [kDevW-1:0] r_dout, w_enc;
  logic [kNumTaps*kWidthScanTdc-1:0] r_table;
  logic [kWidthScanTdc-1:0] w_entry [kNumTaps];
  for (genvar g = 0; g < kNumTaps; g++) begin : g_tap
    localparam logic [31:0] E = offset_entry(g, kNumTaps, kWidthScanTdc);
    assign w_entry[g] = E[kWidthScanTdc-1:0];
  end
  assign txReady      = (r_state == RUN) && !restartScan;
  assign scanFinished = r_state == RUN;
  assign dOutToDevice = r_dout;
  assign offsetTable  = r_table;
  cdcm_pulse_encoder #(.kDevW(kDevW), .kModDepth(kModDepth)) u_enc (
    .i_bit  (txData),
    .i_valid(txValid && txReady),
    .o_word (w_enc)
  );
  // next state: restart dominates, counter clears on every state change and idles in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    if (restartScan) begin
      w_state_nxt = TRAIN;
      w_cnt_nxt   = '0;
    end else if (r_state == TRAIN && r_cnt == kCntW'(kTrainLen - 1)) begin
      w_state_nxt = SCAN;
      w_cnt_nxt   = '0;
    end else if (r_state == SCAN && r_cnt == kCntW'(kNumTaps - 1)) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == RUN) begin
      w_cnt_nxt   = '0;
    end
  end
  // state, counter and output word; the encoder already yields idle outside accepted RUN cycles
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      r_state <= TRAIN;
      r_cnt   <= '0;
      r_dout  <= IDLE_W[kDevW-1:0];
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_enc;
    end
  end
  // offset table: one entry per scan cycle, wiped on restart
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) r_table <= '0;
    else if (restartScan) r_table <= '0;
    else for (int i = 0; i < kNumTaps; i++)
      if (r_state == SCAN && r_cnt == kCntW'(i)) r_table[i*kWidthScanTdc +: kWidthScanTdc] <= w_entry[i];
  end
endmodule

// File: doc/cdcm_tx_scan_encoder.md
Name: cdcm_tx_scan_encoder

Overview:
Parametrised CDCM transmit front-end in the serializer's parallel-clock domain. Converts a 1-bit-per-cycle payload stream into kDevW-bit duty-cycle-modulated waveform words for the serializer. Runs a real post-reset sequence: training, then offset-table scan, then data. Replaces the fixed F0-during-reset pattern and the hard-wired offset table with a sequenced, restartable state machine and a generated table.

Parameters:
kDevW, 8, waveform word width to serializer; even, >=4
kModDepth, 1, pulse-width modulation in bit slots; 1 <= kModDepth < kDevW/2
kNumTaps, 8, offset-table entries; even, >=2
kWidthScanTdc, 8, width of each signed offset entry
kTrainLen, 64, idle-pattern cycles before scan; >=1

Ports:
clkIn  in  1  parallel (CLKDIV-rate) clock
resetN  in  1  asynchronous active-low reset
restartScan  in  1  sync pulse; re-enter training from any state
txData  in  1  payload bit
txValid  in  1  payload bit valid
txReady  out  1  payload accepted when txValid && txReady
dOutToDevice  out  kDevW  waveform word to serializer; MSB sent first
offsetTable  out  kNumTaps*kWidthScanTdc  entry i at [i*kWidthScanTdc +: kWidthScanTdc]
scanFinished  out  1  high while in RUN

Behaviour:
- Pattern P(k): kDevW-bit word, top k bits 1, rest 0.
  - IDLE = P(kDevW/2); ONE = P(kDevW/2+kModDepth); ZERO = P(kDevW/2-kModDepth).
  - Defaults: IDLE=F0, ONE=F8, ZERO=E0.
- Reset (resetN low, async):
  - dOutToDevice=IDLE, offsetTable all 0, scanFinished=0.
  - state=TRAIN, counter=0.
  - txReady=0 (derived from state).
- States and transitions:
  - TRAIN: output IDLE. Counter increments 0..kTrainLen-1. On count kTrainLen-1, go to SCAN with counter=0.
  - SCAN: output IDLE. In scan cycle i, register entry i = (i - kNumTaps/2) as kWidthScanTdc-bit two's complement. Entry i is visible from cycle i+1. After i = kNumTaps-1, go to RUN.
  - RUN: scanFinished=1. If accepted (txValid && txReady), the next dOutToDevice is ONE or ZERO from txData; otherwise the next dOutToDevice is IDLE. Latency is exactly 1 cycle.
- txReady = (state==RUN) && !restartScan. It is combinational from the state register; no bit is accepted in a restart cycle.
- restartScan (any state, highest sync priority):
  - Next state TRAIN, counter=0, offsetTable cleared to 0, scanFinished=0.
  - Next dOutToDevice=IDLE.
  - restartScan held high keeps the block in TRAIN with counter 0.
- Timing: with restartScan low, scanFinished first rises kTrainLen+kNumTaps cycles after the first clkIn edge following reset release.
- Counter width: clog2(max(kTrainLen,kNumTaps))+1. There is no wrap-around in TRAIN or SCAN; the counter is cleared on each state change.
- Reset mid-operation: async return to reset values; the next sequence starts from TRAIN.
- txValid in TRAIN/SCAN: ignored, no accept, data lost by design. Upstream must wait for txReady.

Decomposition:
- Package cdcm_tx_pkg holds:
  - state enum {TRAIN, SCAN, RUN};
  - function pulse_word(width, k) returning P(k);
  - function offset_entry(i, taps, width).
- Sub-module cdcm_pulse_encoder is natural. It is combinational: bit + valid -> ONE/ZERO/IDLE. Output is registered in the parent.

Test Plan:
- Reset values: assert resetN low -> dOutToDevice=F0, offsetTable=0, scanFinished=0, txReady=0. Release, restartScan=0 -> F0 for 72 cycles; scanFinished rises at cycle 72 (defaults).
- Table contents: after scan, offsetTable entries 0..7 = FC,FD,FE,FF,00,01,02,03. Entry 3 is already FF while entry 4 is still 0, one cycle mid-scan.
- RUN encoding: drive txValid=1 with txData 1,0,1, then txValid=0 -> dOutToDevice F8,E0,F8,F0, each one cycle after accept.
- Restart in RUN: pulse restartScan with txValid=1 -> txReady=0 that cycle, no accept. Next cycle scanFinished=0, table=0, output F0; scanFinished returns 72 cycles later.
- Async reset mid-SCAN (entry 2): offsetTable clears immediately without a clock edge; full 72-cycle sequence replays.
- Non-default parameters kDevW=10, kModDepth=2, kNumTaps=4, kTrainLen=3:
  - IDLE=3E0, ONE=3F8, ZERO=380;
  - table = FE,FF,00,01;
  - scanFinished at cycle 7.
